// File: rtl/prio_encoder_pipe_if.sv
// Handshake bundle for prio_encoder_pipe: a valid/ready request port carrying
// the N-bit request vector, and a valid/ready result port carrying the
// encoded index plus the zero/multi flags.
interface prio_encoder_pipe_if #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dec;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         out_zero;
  logic         out_multi;

  // Upstream producer / downstream consumer side (testbench or parent block).
  modport master (
    output in_valid,
    output in_dec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  out_zero,
    input  out_multi
  );

  // The encoder itself.
  modport slave (
    input  in_valid,
    input  in_dec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bin,
    output out_zero,
    output out_multi
  );

endinterface

// File: rtl/prio_encoder_pipe.sv
// Pipelined priority encoder with a single-entry valid/ready output stage.
// A request vector is encoded combinationally and captured into the output
// register on acceptance; the register drains and refills in the same cycle,
// so the block sustains one word per clock. A saturating counter tracks
// accepted words that were empty or had more than one bit set.
//
// MODE selects how multi-hot words are encoded:
//   0 - highest set index wins
//   1 - lowest set index wins
//   2 - strict one-hot: multi-hot words encode as 0
// Any other MODE value behaves as MODE 0.
module prio_encoder_pipe #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prio_encoder_pipe_if.slave   bus,
  input  logic                 err_clr,
  output logic [15:0]          err_cnt
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Encoder results for the word currently on in_dec.
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic         any_set;
  logic         multi_set;
  logic [W-1:0] enc_bin;
  logic         enc_zero;

  // Output stage state.
  logic         out_valid_q;
  logic [W-1:0] out_bin_q;
  logic         out_zero_q;
  logic         out_multi_q;

  logic         accept;
  logic         err_inc;

  // Scan the request vector for highest/lowest set index and popcount > 1.
  // NOTE: every variable written here gets a value before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_idx    = '0;
    lo_idx    = '0;
    any_set   = 1'b0;
    multi_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_dec[i]) begin
        hi_idx    = W'(i);
        multi_set = multi_set | any_set;
        any_set   = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_dec[i]) begin
        lo_idx = W'(i);
      end
    end
  end

  // Select the reported index according to MODE; an empty word encodes as 0
  // because both scans default to 0, and indices never reach N.
  always_comb begin
    enc_bin  = hi_idx;
    enc_zero = ~any_set;
    if (MODE == 1) begin
      enc_bin = lo_idx;
    end else if (MODE == 2) begin
      enc_bin = multi_set ? '0 : hi_idx;
    end
  end

  // Ready whenever the output slot is empty or being drained this cycle;
  // held low during reset so nothing is accepted while rst_n is asserted.
  assign bus.in_ready = rst_n & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign err_inc      = accept & (enc_zero | multi_set);

  // Output register: load on acceptance, drop valid when drained, else hold.
  // NOTE: state is assigned with non-blocking (<=) so every register samples
  // its inputs from before the edge, independent of statement order.
  // NOTE: the data fields are reset too, because their values are visible on
  // the ports and must read as zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_bin_q   <= enc_bin;
      out_zero_q  <= enc_zero;
      out_multi_q <= multi_set;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating error counter; a clear wins over the old count but still
  // records an erroneous word accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= {15'd0, err_inc};
    end else if (err_inc && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_multi = out_multi_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench for prio_encoder_pipe. Three N=8 instances (MODE 0/1/2)
// share one stimulus stream; an N=5 MODE=1 instance has its own. Stimulus
// tasks push hand-computed expectations into per-instance queues; a monitor
// on the falling edge pops and compares whenever a result is handed over.
module tb_prio_encoder_pipe;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        in_valid;
  logic [7:0]  in_dec;
  logic        out_ready;
  logic        in_valid5;
  logic [4:0]  in_dec5;
  logic        out_ready5;
  logic [15:0] err_cnt0;
  logic [15:0] err_cnt1;
  logic [15:0] err_cnt2;
  logic [15:0] err_cnt5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prio_encoder_pipe_if #(.N(8)) b0 ();
  prio_encoder_pipe_if #(.N(8)) b1 ();
  prio_encoder_pipe_if #(.N(8)) b2 ();
  prio_encoder_pipe_if #(.N(5)) b5 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_dec    = in_dec;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_dec    = in_dec;
  assign b1.out_ready = out_ready;
  assign b2.in_valid  = in_valid;
  assign b2.in_dec    = in_dec;
  assign b2.out_ready = out_ready;
  assign b5.in_valid  = in_valid5;
  assign b5.in_dec    = in_dec5;
  assign b5.out_ready = out_ready5;

  prio_encoder_pipe #(.N(8), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .err_clr(err_clr), .err_cnt(err_cnt0));
  prio_encoder_pipe #(.N(8), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .err_clr(err_clr), .err_cnt(err_cnt1));
  prio_encoder_pipe #(.N(8), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .err_clr(err_clr), .err_cnt(err_cnt2));
  prio_encoder_pipe #(.N(5), .MODE(1)) u_n5 (
    .clk(clk), .rst_n(rst_n), .bus(b5), .err_clr(err_clr), .err_cnt(err_cnt5));

  typedef struct {
    logic [7:0] bin;
    logic       zero;
    logic       multi;
    int         due;
  } exp_t;

  exp_t sb_q[4][$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   sb_en  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic mon(input int id, input logic v, input logic r,
                     input logic [7:0] bin, input logic z, input logic m);
    exp_t e;
    if (sb_q[id].size() != 0 && sb_q[id][0].due == cyc)
      check($sformatf("dut%0d latency valid", id), 32'(v), 32'd1);
    if (v === 1'b1 && r === 1'b1) begin
      if (sb_q[id].size() == 0) begin
        fail_now($sformatf("dut%0d unexpected output bin=%0d", id, bin));
      end else begin
        e = sb_q[id].pop_front();
        check($sformatf("dut%0d out_bin", id), 32'(bin), 32'(e.bin));
        check($sformatf("dut%0d out_zero", id), 32'(z), 32'(e.zero));
        check($sformatf("dut%0d out_multi", id), 32'(m), 32'(e.multi));
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      mon(0, b0.out_valid, b0.out_ready, 8'(b0.out_bin), b0.out_zero, b0.out_multi);
      mon(1, b1.out_valid, b1.out_ready, 8'(b1.out_bin), b1.out_zero, b1.out_multi);
      mon(2, b2.out_valid, b2.out_ready, 8'(b2.out_bin), b2.out_zero, b2.out_multi);
      mon(3, b5.out_valid, b5.out_ready, 8'(b5.out_bin), b5.out_zero, b5.out_multi);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word to the three N=8 instances with per-mode expected codes.
  task automatic send8(input logic [7:0] dec, input logic [2:0] e0, input logic [2:0] e1,
                       input logic [2:0] e2, input logic z, input logic m);
    int waited = 0;
    in_valid = 1'b1;
    in_dec   = dec;
    @(negedge clk);
    while (b0.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) fail_now("send8 in_ready timeout");
    sb_q[0].push_back('{bin: 8'(e0), zero: z, multi: m, due: cyc + 1});
    sb_q[1].push_back('{bin: 8'(e1), zero: z, multi: m, due: cyc + 1});
    sb_q[2].push_back('{bin: 8'(e2), zero: z, multi: m, due: cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send5(input logic [4:0] dec, input logic [2:0] e, input logic z, input logic m);
    int waited = 0;
    in_valid5 = 1'b1;
    in_dec5   = dec;
    @(negedge clk);
    while (b5.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) fail_now("send5 in_ready timeout");
    sb_q[3].push_back('{bin: 8'(e), zero: z, multi: m, due: cyc + 1});
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    err_clr    = 1'b0;
    in_valid   = 1'b0;
    in_dec     = '0;
    out_ready  = 1'b1;
    in_valid5  = 1'b0;
    in_dec5    = '0;
    out_ready5 = 1'b1;

    // Reset state.
    idle(3);
    @(negedge clk);
    check("in_ready during reset", 32'(b0.in_ready), 32'd0);
    check("out_valid after reset", 32'(b0.out_valid), 32'd0);
    check("out_bin after reset", 32'(b0.out_bin), 32'd0);
    check("out_zero after reset", 32'(b0.out_zero), 32'd0);
    check("out_multi after reset", 32'(b0.out_multi), 32'd0);
    check("err_cnt after reset", 32'(err_cnt0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after release", 32'(b0.in_ready), 32'd1);
    check("n5 in_ready after release", 32'(b5.in_ready), 32'd1);
    @(posedge clk); #1;

    // One-hot stream, back to back.
    for (int i = 0; i < 8; i++)
      send8(8'(1 << i), 3'(i), 3'(i), 3'(i), 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    check("out_valid drained", 32'(b0.out_valid), 32'd0);
    check("err_cnt m0 after stream", 32'(err_cnt0), 32'd0);
    check("err_cnt m1 after stream", 32'(err_cnt1), 32'd0);
    check("err_cnt m2 after stream", 32'(err_cnt2), 32'd0);
    @(posedge clk); #1;

    // Zero word and multi-hot word in every mode.
    send8(8'h00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    send8(8'hA4, 3'd7, 3'd2, 3'd0, 1'b0, 1'b1);

    // Backpressure: 8'h10 held for three cycles while 8'h20 waits.
    send8(8'h10, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_dec    = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready", 32'(b0.in_ready), 32'd0);
      check("stall out_valid", 32'(b0.out_valid), 32'd1);
      check("stall out_bin", 32'(b0.out_bin), 32'd4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send8(8'h20, 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    check("err_cnt m0 zero+multi", 32'(err_cnt0), 32'd2);
    check("err_cnt m1 zero+multi", 32'(err_cnt1), 32'd2);
    check("err_cnt m2 zero+multi", 32'(err_cnt2), 32'd2);
    @(posedge clk); #1;

    // N=5, MODE=1.
    send5(5'b10000, 3'd4, 1'b0, 1'b0);
    send5(5'b11000, 3'd3, 1'b0, 1'b1);
    send5(5'b00001, 3'd0, 1'b0, 1'b0);
    send5(5'b00000, 3'd0, 1'b1, 1'b0);
    send5(5'b10101, 3'd0, 1'b0, 1'b1);
    idle(2);
    @(negedge clk);
    check("n5 err_cnt", 32'(err_cnt5), 32'd3);
    @(posedge clk); #1;

    // Counter saturation and clear-with-increment.
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cnt cleared", 32'(err_cnt0), 32'd0);
    @(posedge clk); #1;
    sb_en    = 1'b0;
    in_valid = 1'b1;
    in_dec   = 8'h00;
    idle(65535);
    in_valid = 1'b0;
    idle(1);
    sb_en = 1'b1;
    @(negedge clk);
    check("err_cnt m0 preload", 32'(err_cnt0), 32'hFFFF);
    check("err_cnt m2 preload", 32'(err_cnt2), 32'hFFFF);
    @(posedge clk); #1;
    send8(8'h00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("err_cnt m0 saturated", 32'(err_cnt0), 32'hFFFF);
    check("err_cnt m1 saturated", 32'(err_cnt1), 32'hFFFF);
    @(posedge clk); #1;
    err_clr = 1'b1;
    send8(8'h00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cnt m0 clear+inc", 32'(err_cnt0), 32'd1);
    check("err_cnt m2 clear+inc", 32'(err_cnt2), 32'd1);
    @(posedge clk); #1;

    // Reset while a result is held under backpressure.
    send8(8'h01, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("held before reset", 32'(b0.out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_dec   = 8'h80;
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    idle(1);
    @(negedge clk);
    check("reset drops out_valid", 32'(b0.out_valid), 32'd0);
    check("reset clears out_bin", 32'(b0.out_bin), 32'd0);
    check("reset clears err_cnt", 32'(err_cnt0), 32'd0);
    check("in_ready held in reset", 32'(b0.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready after mid reset", 32'(b0.in_ready), 32'd1);
    check("nothing accepted in reset", 32'(b0.out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send8(8'h02, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
    idle(2);

    for (int k = 0; k < 4; k++)
      check($sformatf("scoreboard %0d empty", k), 32'(sb_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_pipe.md
PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning input vector width; legal range 2..256.
REQ-002 The block SHALL have parameter MODE, default 0, meaning encode mode: 0 = highest set index wins, 1 = lowest set index wins, 2 = strict one-hot.
REQ-003 The block SHALL derive localparam W = max(1, ceil(log2(N))), meaning output code width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_dec  input  N  one-hot / multi-hot request vector.
REQ-009 out_valid  output  1  encoded result present.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_bin  output  W  encoded index.
REQ-012 out_zero  output  1  the accepted word had no bit set.
REQ-013 out_multi  output  1  the accepted word had more than one bit set.
REQ-014 err_clr  input  1  clear the error counter.
REQ-015 err_cnt  output  16  saturating count of accepted words with out_zero or out_multi set.

Function
REQ-016 The block SHALL accept a word when in_valid and in_ready are both 1 at a rising edge.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) while rst_n is 1, and SHALL be 0 while rst_n is 0.
REQ-018 An accepted word SHALL appear on out_bin/out_zero/out_multi with out_valid=1 exactly one cycle after acceptance (latency 1).
REQ-019 While out_valid=1 and out_ready=0, out_bin, out_zero, out_multi and out_valid SHALL hold their values.
REQ-020 When out_valid=1, out_ready=1 and no new word is accepted, out_valid SHALL go to 0 on the next edge.
REQ-021 Simultaneous output drain and input acceptance SHALL replace the result with no bubble (full throughput, one word per cycle).
REQ-022 Zero input: out_bin=0, out_zero=1, out_multi=0 in every MODE.
REQ-023 Exactly one bit k set: out_bin=k, out_zero=0, out_multi=0 in every MODE.
REQ-024 Multiple bits set: out_multi=1; out_bin=highest set index (MODE 0), lowest set index (MODE 1), 0 (MODE 2).
REQ-025 out_bin SHALL be zero-extended when N is not a power of two; codes >= N SHALL never be produced.
REQ-026 err_cnt SHALL increment by 1 on each accepted word whose result has out_zero or out_multi set, and SHALL saturate at 16'hFFFF.
REQ-027 err_clr=1 SHALL set err_cnt to 0 on the next edge; if an erroneous word is accepted in the same cycle, err_cnt SHALL become 1.
REQ-028 The output register SHALL load only on acceptance; in_dec is don't-care when in_valid=0.

Reset
REQ-029 On a rising edge with rst_n=0: out_valid=0, out_bin=0, out_zero=0, out_multi=0, err_cnt=0.
REQ-030 Reset mid-operation SHALL discard any held result; no word presented during reset SHALL be accepted.
REQ-031 Function SHALL resume on the first edge after rst_n returns to 1, with in_ready=1.

Verification
REQ-032 N=8, MODE=0, out_ready=1: stream 8'h01,8'h02,...,8'h80 back-to-back -> out_bin 0..7 on consecutive cycles, one cycle late, flags 0, err_cnt=0.
REQ-033 N=8: in_dec=8'h00 then 8'h A4 in MODE 0/1/2 -> zero word: bin 0, out_zero=1; 8'hA4: bin 7 / 2 / 0 with out_multi=1; err_cnt=2.
REQ-034 Backpressure: accept 8'h10, hold out_ready=0 for 3 cycles with in_valid=1, in_dec=8'h20 -> in_ready=0, out_bin=4 stable; release -> 5 follows next cycle, no loss or duplication.
REQ-035 N=5, MODE=1: in_dec=5'b10000 -> out_bin=3'd4; 5'b11000 -> 3'd3, out_multi=1.
REQ-036 err_cnt preloaded to 16'hFFFF via 65535 zero words, one more -> stays 16'hFFFF; err_clr with a zero word accepted same cycle -> err_cnt=1.
REQ-037 rst_n=0 asserted while out_valid=1, out_ready=0 -> next edge out_valid=0, err_cnt=0, in_ready=0 during reset, 1 after release.
